burst_rr_arbiter: RTL
=====================

Name: burst_rr_arbiter

Overview:
Shares one downstream count-burst engine among N requesters using round-robin arbitration. The engine uses an rdy/ack handshake: it takes a length L and emits beats 0..L. This block sequences each job: grant, issue the length, stream the beats back, then release. It sits between the requester ports and the single engine instance, and tags each output beat with the owning requester id.

Parameters:
N, 4, number of requesters (2..16)
W, 11, width of length and beat data
IDW, $clog2(N), width of requester id

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req_rdy  input  N  requester i has a job pending; held until its req_ack
req_ack  output  N  one-hot; job accepted by engine this cycle
req_len  input  N*W  job length L, slice i = [i*W +: W]
dut_irdy  output  1  job valid to engine
dut_iack  input  1  engine accepted job
dut_iint  output  W  length of granted job
dut_ordy  input  1  engine beat valid
dut_oack  output  1  beat consumed
dut_oint  input  W  engine beat value
out_rdy  output  1  beat valid to sink
out_ack  input  1  sink accepts beat
out_data  output  W  beat value
out_id  output  IDW  owner of current beat
out_last  output  1  final beat of job (out_data == L)

Behaviour:
- Transfer on any interface = rdy && ack in the same cycle. rdy, once high, holds with stable data until the transfer.
- FSM states: IDLE, ISSUE, STREAM. Registered state, grant id (gnt_r) and length (len_r).
- IDLE: if any req_rdy is high, pick a winner and latch gnt_r and len_r = req_len[winner]. Next state is ISSUE. Otherwise stay in IDLE.
- Round-robin: ptr holds the last granted id. The search order is ptr+1, ptr+2, ... mod N, and the first set bit wins. ptr updates to the winner at grant. Reset value of ptr is N-1, so requester 0 has first priority.
- ISSUE: dut_irdy=1, dut_iint=len_r. On dut_iack, req_ack[gnt_r]=1 for that cycle (combinational, no extra delay) and the next state is STREAM. req_ack is 0 in every other state and for every other bit.
- STREAM: out_rdy=dut_ordy, out_data=dut_oint, out_id=gnt_r, out_last=dut_ordy && (dut_oint==len_r). dut_oack=out_ack && dut_ordy.
- STREAM exit: a transfer with out_last=1 moves the FSM to IDLE. The next grant can occur in the following cycle.
- Outside STREAM: out_rdy=0, out_last=0, dut_oack=0, and out_ack is ignored. out_data and out_id hold their last values.
- Arbitration latency: req_rdy seen in IDLE at cycle t gives dut_irdy at t+1. The minimum gap between the last beat of one job and the next dut_irdy is 2 cycles.
- A job with L=0 produces exactly one beat, with out_data=0 and out_last=1.
- L = 2^W-1 is legal. The final beat is 2^W-1. The comparison uses W bits with no wrap beyond it.
- A requester that drops req_rdy before its ack is a protocol violation. A non-granted requester may change req_rdy freely.
- Requests arriving during ISSUE or STREAM wait; each job is granted exactly once.
- Reset:
  - FSM=IDLE, gnt_r=0, len_r=0, ptr=N-1.
  - All outputs are 0: req_ack, dut_irdy, dut_iint, dut_oack, out_rdy, out_data, out_id, out_last.
- Reset mid-job abandons the job with no req_ack or out_last. The engine must be reset in the same cycle.

Optional Feature:
BURST_RR_FIXED_PRIO_EN. Defined: the IDLE winner is the lowest-index set req_rdy bit; ptr is unused and held at reset value. Undefined: round-robin as above. The interface and timing are identical in both builds.

Test Plan:
- Single job: req_rdy[2]=1, L=3.
  - dut_irdy rises 1 cycle later; req_ack[2] is asserted in the dut_iack cycle.
  - Output beats are 0,1,2,3 with out_id=2, and out_last only on 3.
- Round-robin: after reset, requesters 0, 1 and 3 each request, L=1, held continuously.
  - Grant order is 0,1,3,0,...; each requester gets 2 beats per job.
  - Under BURST_RR_FIXED_PRIO_EN the order is 0,0,0 while req 0 stays asserted.
- Length boundaries: L=0 gives one beat, data 0, out_last=1. L=2047 (W=11) gives 2048 beats, with last data 2047.
- Back-pressure: out_ack toggles randomly during L=5.
  - dut_oack equals out_ack && dut_ordy; no beat is lost or duplicated.
  - out_data is stable while out_rdy=1 and out_ack=0.
- Late arrival: req 1 rises during STREAM of req 0's job.
  - It is not acked until req 0's last beat transfers.
  - dut_irdy for req 1 appears 2 cycles after that beat.
- Reset mid-STREAM: assert rst for 1 cycle after beat 2 of L=5.
  - All outputs are 0 the next cycle and ptr=N-1.
  - A new req 0 job runs cleanly.

Source files
------------

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter sharing one count-burst engine among N requesters; tags each beat with its owner.
// Define BURST_RR_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module burst_rr_arbiter #(
  parameter int N   = 4,
  parameter int W   = 11,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_rdy,
  output logic [N-1:0]     req_ack,
  input  logic [N*W-1:0]   req_len,
  output logic             dut_irdy,
  input  logic             dut_iack,
  output logic [W-1:0]     dut_iint,
  input  logic             dut_ordy,
  output logic             dut_oack,
  input  logic [W-1:0]     dut_oint,
  output logic             out_rdy,
  input  logic             out_ack,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  output logic             out_last
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   len_q, len_d;
  logic [W-1:0]   data_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] win;

  // Scan in reverse search order so the last hit is the first requester in priority order.
  always_comb begin
    win = '0;
`ifdef BURST_RR_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rdy[i]) win = IDW'(i);
    end
`else
    for (int k = N; k >= 1; k--) begin
      if (req_rdy[(int'(ptr_q) + k) % N]) win = IDW'((int'(ptr_q) + k) % N);
    end
`endif
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    req_ack  = '0;
    dut_irdy = 1'b0;
    dut_oack = 1'b0;
    out_rdy  = 1'b0;
    out_last = 1'b0;
    out_data = data_q;
    out_id   = id_q;
    case (state_q)
      S_IDLE: begin
        if (|req_rdy) begin
          gnt_d   = win;
          len_d   = req_len[int'(win) * W +: W];
`ifndef BURST_RR_FIXED_PRIO_EN
          ptr_d   = win;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dut_irdy = 1'b1;
        if (dut_iack) begin
          req_ack[gnt_q] = 1'b1;
          state_d        = S_STREAM;
        end
      end
      S_STREAM: begin
        out_rdy  = dut_ordy;
        out_data = dut_oint;
        out_id   = gnt_q;
        out_last = dut_ordy && (dut_oint == len_q);
        dut_oack = out_ack && dut_ordy;
        if (out_last && out_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_iint = len_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= IDW'(N - 1);
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      // Track the last streamed beat so out_data/out_id hold it outside STREAM.
      if (state_q == S_STREAM) begin
        data_q <= dut_oint;
        id_q   <= gnt_q;
      end
    end
  end

endmodule
